// File: rtl/cache_pkg.sv
// Shared types and constants for the cache refill arbiter.
package cache_pkg;

  localparam int AW          = 16;
  localparam int WORDS       = 8;
  localparam int MEM_LAT     = 4;
  localparam int IW          = $clog2(WORDS) + 1;
  localparam logic [AW-1:0] OFFSET_MASK = 16'h000F;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STORE  = 2'd1,
    FILL_I = 2'd2,
    FILL_D = 2'd3
  } state_t;

  // Fixed priority: store write-through, then D miss, then I miss.
  function automatic state_t arbitrate(input logic wr, input logic dm, input logic im);
    state_t s;
    s = IDLE;
    if (wr)      s = STORE;
    else if (dm) s = FILL_D;
    else if (im) s = FILL_I;
    return s;
  endfunction

endpackage

// File: rtl/cache_refill_arbiter_if.sv
// Cache/memory side signals of the refill arbiter. master = arbiter,
// slave = the caches and memory around it.
interface cache_refill_arbiter_if;
  import cache_pkg::*;

  logic          i_miss;
  logic [AW-1:0] i_miss_addr;
  logic          d_miss;
  logic [AW-1:0] d_miss_addr;
  logic          d_wr_req;
  logic [AW-1:0] d_wr_addr;
  logic [15:0]   d_wr_data;
  logic          d_wr_ack;
  logic          mem_enable;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic          mem_data_valid;
  logic [AW-1:0] fill_addr;
  logic          i_data_wr;
  logic          i_tag_wr;
  logic          d_data_wr;
  logic          d_tag_wr;
  logic          i_busy;
  logic          d_busy;
  logic          stall;

  modport master (
    input  i_miss, i_miss_addr, d_miss, d_miss_addr, d_wr_req, d_wr_addr,
           d_wr_data, mem_data_valid,
    output d_wr_ack, mem_enable, mem_wr, mem_addr, mem_wdata, fill_addr,
           i_data_wr, i_tag_wr, d_data_wr, d_tag_wr, i_busy, d_busy, stall
  );

  modport slave (
    output i_miss, i_miss_addr, d_miss, d_miss_addr, d_wr_req, d_wr_addr,
           d_wr_data, mem_data_valid,
    input  d_wr_ack, mem_enable, mem_wr, mem_addr, mem_wdata, fill_addr,
           i_data_wr, i_tag_wr, d_data_wr, d_tag_wr, i_busy, d_busy, stall
  );

endinterface

// File: rtl/refill_counter.sv
// Issue/return word counters for one block refill and the derived
// memory-side and cache-side word addresses.
module refill_counter
  import cache_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_iss_en,
  input  logic          i_ret_en,
  input  logic [AW-1:0] i_base,
  output logic          o_iss_done,
  output logic          o_ret_avail,
  output logic          o_ret_last,
  output logic [AW-1:0] o_rd_addr,
  output logic [AW-1:0] o_fill_addr
);

  logic [IW-1:0] r_iss;
  logic [IW-2:0] r_ret;

  // Count issued reads and returned words; cleared when the block completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_iss <= '0;
      r_ret <= '0;
    end else if (i_clr) begin
      r_iss <= '0;
      r_ret <= '0;
    end else begin
      if (i_iss_en) r_iss <= r_iss + 1'b1;
      if (i_ret_en) r_ret <= r_ret + 1'b1;
    end
  end

  // A return is only legal for a word already issued; extra valids are dropped.
  always_comb begin
    o_iss_done  = (r_iss == IW'(WORDS));
    o_ret_avail = ({1'b0, r_ret} < r_iss);
    o_ret_last  = (r_ret == (IW-1)'(WORDS-1));
    o_rd_addr   = i_base + (AW'(r_iss) << 1);
    o_fill_addr = i_base + (AW'(r_ret) << 1);
  end

endmodule

// File: rtl/cache_refill_arbiter.sv
// Owner of the shared memory: arbitrates stores and I/D block refills.
//
//   state  | meaning
//   IDLE   | no access; picks the next request
//   STORE  | one-cycle write-through of d_wr_data
//   FILL_I | I-cache block refill (issue + return)
//   FILL_D | D-cache block refill (issue + return)
//
// STORE and the final return of a fill re-arbitrate directly, so a pending
// request starts on the next cycle. The request just serviced is excluded
// from that decision because its cache only drops it after the ack/tag.
module cache_refill_arbiter
  import cache_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  cache_refill_arbiter_if.master bus
);

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_base, w_base_nxt;
  logic          w_fill, w_iss_done, w_ret_avail, w_ret_last, w_ret_en, w_last;
  logic [AW-1:0] w_rd_addr, w_fill_addr;

  assign w_fill   = (r_state == FILL_I) || (r_state == FILL_D);
  assign w_ret_en = w_fill & bus.mem_data_valid & w_ret_avail;
  assign w_last   = w_ret_en & w_ret_last;

  refill_counter u_cnt (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (w_last),
    .i_iss_en    (w_fill & ~w_iss_done),
    .i_ret_en    (w_ret_en),
    .i_base      (r_base),
    .o_iss_done  (w_iss_done),
    .o_ret_avail (w_ret_avail),
    .o_ret_last  (w_ret_last),
    .o_rd_addr   (w_rd_addr),
    .o_fill_addr (w_fill_addr)
  );

  // State and latched block base.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_base  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_base  <= w_base_nxt;
    end
  end

  // Next state and base capture whenever an arbitration decision is taken.
  always_comb begin
    w_state_nxt = r_state;
    w_base_nxt  = r_base;
    case (r_state)
      IDLE:    w_state_nxt = arbitrate(bus.d_wr_req, bus.d_miss, bus.i_miss);
      STORE:   w_state_nxt = arbitrate(1'b0, bus.d_miss, bus.i_miss);
      FILL_I:  if (w_last) w_state_nxt = arbitrate(bus.d_wr_req, bus.d_miss, 1'b0);
      FILL_D:  if (w_last) w_state_nxt = arbitrate(bus.d_wr_req, 1'b0, bus.i_miss);
      default: w_state_nxt = IDLE;
    endcase
    if (!w_fill || w_last) begin
      case (w_state_nxt)
        FILL_I:  w_base_nxt = bus.i_miss_addr & ~OFFSET_MASK;
        FILL_D:  w_base_nxt = bus.d_miss_addr & ~OFFSET_MASK;
        default: w_base_nxt = r_base;
      endcase
    end
  end

  // Memory commands, cache strobes and busy flags per state.
  always_comb begin
    bus.d_wr_ack   = 1'b0;
    bus.mem_enable = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.fill_addr  = '0;
    bus.i_data_wr  = 1'b0;
    bus.i_tag_wr   = 1'b0;
    bus.d_data_wr  = 1'b0;
    bus.d_tag_wr   = 1'b0;
    bus.i_busy     = 1'b0;
    bus.d_busy     = 1'b0;
    case (r_state)
      STORE: begin
        bus.mem_enable = 1'b1;
        bus.mem_wr     = 1'b1;
        bus.mem_addr   = bus.d_wr_addr;
        bus.mem_wdata  = bus.d_wr_data;
        bus.d_wr_ack   = 1'b1;
        bus.d_busy     = 1'b1;
      end
      FILL_I, FILL_D: begin
        bus.fill_addr = w_fill_addr;
        if (!w_iss_done) begin
          bus.mem_enable = 1'b1;
          bus.mem_addr   = w_rd_addr;
        end
        if (r_state == FILL_I) begin
          bus.i_busy    = 1'b1;
          bus.i_data_wr = w_ret_en;
          bus.i_tag_wr  = w_last;
        end else begin
          bus.d_busy    = 1'b1;
          bus.d_data_wr = w_ret_en;
          bus.d_tag_wr  = w_last;
        end
      end
      default: ;
    endcase
    bus.stall = bus.i_busy | bus.d_busy;
  end

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Directed bench for cache_refill_arbiter with a fixed-latency memory model.
module tb_cache_refill_arbiter;
  import cache_pkg::*;

  logic clk;
  logic rst;
  logic [3:0] pend;
  int n_chk;
  int n_pass;

  cache_refill_arbiter_if bus();

  cache_refill_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, act, exp_v, $time);
  endtask

  // Advance one cycle; memory returns each accepted read 4 cycles later.
  task automatic next_cyc();
    logic issue;
    issue = bus.mem_enable & ~bus.mem_wr;
    @(posedge clk);
    #2;
    pend = {pend[2:0], issue};
    bus.mem_data_valid = pend[3];
  endtask

  function automatic logic [9:0] all_outs();
    return {bus.mem_enable, bus.mem_wr, bus.d_wr_ack, bus.i_data_wr, bus.i_tag_wr,
            bus.d_data_wr, bus.d_tag_wr, bus.i_busy, bus.d_busy, bus.stall};
  endfunction

  // Checks a 12-cycle refill starting at the current cycle (T).
  task automatic run_fill(input logic is_d, input logic [15:0] base,
                          input int raise_at, input logic [15:0] raise_addr);
    logic [3:0] exp_str;
    logic data, tag;
    for (int k = 0; k < 12; k++) begin
      if (k == raise_at) begin
        bus.d_miss      = 1'b1;
        bus.d_miss_addr = raise_addr;
        bus.i_miss_addr = 16'h7770;
      end
      #1;
      data = (k >= 4);
      tag  = (k == 11);
      exp_str = is_d ? {2'b00, data, tag} : {data, tag, 2'b00};
      chk("busy", {bus.i_busy, bus.d_busy, bus.stall}, is_d ? 3'b011 : 3'b101);
      chk("strobes", {bus.i_data_wr, bus.i_tag_wr, bus.d_data_wr, bus.d_tag_wr}, exp_str);
      chk("mem_en", {bus.mem_enable, bus.mem_wr}, (k < 8) ? 2'b10 : 2'b00);
      if (k < 8) chk("mem_addr", bus.mem_addr, base + 16'(2 * k));
      if (k >= 4) chk("fill_addr", bus.fill_addr, base + 16'(2 * (k - 4)));
      next_cyc();
    end
    if (is_d) bus.d_miss = 1'b0;
    else      bus.i_miss = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_chk = 0;
    n_pass = 0;
    pend = '0;
    rst = 1'b1;
    bus.i_miss = 0; bus.i_miss_addr = 0;
    bus.d_miss = 0; bus.d_miss_addr = 0;
    bus.d_wr_req = 0; bus.d_wr_addr = 0; bus.d_wr_data = 0;
    bus.mem_data_valid = 0;
    #1;
    chk("rst_outs", 32'(all_outs()), 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_fill_addr", bus.fill_addr, 0);
    next_cyc();
    rst = 1'b0;
    next_cyc();

    // I refill of 0x1236
    bus.i_miss = 1; bus.i_miss_addr = 16'h1236;
    #1 chk("idle_stall", bus.stall, 0);
    next_cyc();
    run_fill(1'b0, 16'h1230, -1, 16'h0);
    #1 chk("after_i_outs", 32'(all_outs()), 0);
    next_cyc();

    // spurious valid in IDLE
    bus.mem_data_valid = 1;
    #1 chk("spur_outs", 32'(all_outs()), 0);
    next_cyc();
    #1 chk("spur_next_outs", 32'(all_outs()), 0);

    // simultaneous misses: D first, I follows with no gap
    bus.i_miss = 1; bus.i_miss_addr = 16'h0040;
    bus.d_miss = 1; bus.d_miss_addr = 16'h2008;
    next_cyc();
    run_fill(1'b1, 16'h2000, -1, 16'h0);
    run_fill(1'b0, 16'h0040, -1, 16'h0);
    #1 chk("after_sim_outs", 32'(all_outs()), 0);
    next_cyc();

    // store then miss
    bus.d_wr_req = 1; bus.d_wr_addr = 16'h3002; bus.d_wr_data = 16'hBEEF;
    bus.d_miss = 1; bus.d_miss_addr = 16'h3004;
    next_cyc();
    #1;
    chk("st_ctl", {bus.mem_enable, bus.mem_wr, bus.d_wr_ack, bus.d_busy, bus.i_busy}, 5'b11110);
    chk("st_addr", bus.mem_addr, 16'h3002);
    chk("st_wdata", bus.mem_wdata, 16'hBEEF);
    next_cyc();
    bus.d_wr_req = 0; bus.d_wr_addr = 16'h9990;
    run_fill(1'b1, 16'h3000, -1, 16'h0);
    #1 chk("after_st_outs", 32'(all_outs()), 0);

    // no preemption: D raised at I cycle T+2, I address changes mid-fill
    bus.i_miss = 1; bus.i_miss_addr = 16'h0100;
    next_cyc();
    run_fill(1'b0, 16'h0100, 2, 16'h4006);
    run_fill(1'b1, 16'h4000, -1, 16'h0);
    next_cyc();

    // reset mid-fill
    bus.i_miss = 1; bus.i_miss_addr = 16'h5678;
    next_cyc();
    #1 chk("rf_busy", bus.i_busy, 1);
    next_cyc();
    next_cyc();
    next_cyc();
    rst = 1; bus.i_miss = 0;
    #1;
    chk("rf_abort_outs", 32'(all_outs()), 0);
    chk("rf_abort_maddr", bus.mem_addr, 0);
    next_cyc();
    rst = 0;
    #1;
    chk("rf_valid_seen", bus.mem_data_valid, 1);
    chk("rf_t4_outs", 32'(all_outs()), 0);
    for (int k = 0; k < 3; k++) begin
      next_cyc();
      #1 chk("rf_idle_outs", 32'(all_outs()), 0);
    end
    bus.i_miss = 1;
    next_cyc();
    run_fill(1'b0, 16'h5670, -1, 16'h0);
    #1 chk("final_outs", 32'(all_outs()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
